// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result/display path.
// The segment patterns are stored lit-low, matching the board's native polarity.
package alu_pkg;

    typedef logic [3:0] nibble_t;

    typedef struct packed {
        nibble_t value;
        logic    V;
        logic    Z;
    } result_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // {g,f,e,d,c,b,a} per hex digit; element 15 comes first in the concatenation
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] seg_pattern(input nibble_t value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-7-segment decoder with selectable drive polarity.
// Shared by every ALU operation display on the board.
module hex_to_7seg
    import alu_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_pattern(value);
        if (!SEG_ACTIVE_LOW) begin
            seg = ~seg;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// One-entry valid/ready output buffer behind the 4-bit ALU, with sticky flags
// and a 7-segment/LED display that blinks while the shown result overflowed.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int BLINK_DIV      = 25_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] result,
    input  logic       V,
    input  logic       Z,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_V,
    output logic       out_Z,
    input  logic       clear,
    output logic       sticky_V,
    output logic       sticky_Z,
    output logic [6:0] seg,
    output logic [1:0] led
);

    localparam int              CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    stage_state_t     state_q, state_d;
    result_t          buf_q, buf_d;
    result_t          disp_q, disp_d;
    logic             sticky_v_q, sticky_v_d;
    logic             sticky_z_q, sticky_z_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_dark_q, blink_dark_d;

    logic             accept;
    logic             drain;
    logic [6:0]       digit_seg;
    logic [6:0]       blank_seg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            buf_q        <= '0;
            disp_q       <= '0;
            sticky_v_q   <= 1'b0;
            sticky_z_q   <= 1'b0;
            blink_cnt_q  <= '0;
            blink_dark_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            disp_q       <= disp_d;
            sticky_v_q   <= sticky_v_d;
            sticky_z_q   <= sticky_z_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_dark_q <= blink_dark_d;
        end
    end

    // A full buffer that is draining still takes a new entry in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (drain && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        in_ready  = (state_q == EMPTY) || out_ready;
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        buf_d  = buf_q;
        disp_d = disp_q;
        if (accept) begin
            buf_d.value = result;
            buf_d.V     = V;
            buf_d.Z     = Z;
            disp_d      = buf_d;
        end
        sticky_v_d = (sticky_v_q && !clear) || (accept && V);
        sticky_z_d = (sticky_z_q && !clear) || (accept && Z);
    end

    // A fresh result restarts the blink in the lit phase so it is seen at once
    always_comb begin
        blink_cnt_d  = blink_cnt_q;
        blink_dark_d = blink_dark_q;
        if (accept) begin
            blink_cnt_d  = '0;
            blink_dark_d = 1'b0;
        end else if (blink_cnt_q == CNT_LAST) begin
            blink_cnt_d  = '0;
            blink_dark_d = !blink_dark_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
    end

    hex_to_7seg #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_digit (
        .value(disp_q.value),
        .seg  (digit_seg)
    );

    assign blank_seg  = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
    assign seg        = (disp_q.V && blink_dark_q) ? blank_seg : digit_seg;
    assign led        = {disp_q.V, disp_q.Z};
    assign out_result = buf_q.value;
    assign out_V      = buf_q.V;
    assign out_Z      = buf_q.Z;
    assign sticky_V   = sticky_v_q;
    assign sticky_Z   = sticky_z_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: a scoreboard queue tracks accepted
// results until they drain, and per-scenario tasks check display and flags.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] result;
    logic       V;
    logic       Z;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_V;
    logic       out_Z;
    logic       clear;
    logic       sticky_V;
    logic       sticky_Z;
    logic [6:0] seg;
    logic [1:0] led;

    int vectors     = 0;
    int miscompares = 0;

    logic [5:0] sb[$];

    localparam logic [6:0] SEG_EXP [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    alu_result_stage #(
        .BLINK_DIV     (4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .V         (V),
        .Z         (Z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_V     (out_V),
        .out_Z     (out_Z),
        .clear     (clear),
        .sticky_V  (sticky_V),
        .sticky_Z  (sticky_Z),
        .seg       (seg),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Advance one clock; at the falling edge compare the buffered entry against
    // the scoreboard front, then record the drain/accept that the edge commits.
    task automatic step();
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL sb_empty: out_valid=1 with no entry expected, got %h", {out_result, out_V, out_Z});
                end else if ({out_result, out_V, out_Z} !== sb[0]) begin
                    miscompares++;
                    $display("[TB] FAIL sb_data: got result=%h V=%b Z=%b expected result=%h V=%b Z=%b",
                             out_result, out_V, out_Z, sb[0][5:2], sb[0][1], sb[0][0]);
                end
            end
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (in_valid && in_ready) sb.push_back({result, V, Z});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_result, out_V, out_Z} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got %b expected 0000000", {out_valid, out_result, out_V, out_Z});
        end
        vectors++;
        if ({sticky_V, sticky_Z, led} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {sticky_V, sticky_Z, led});
        end
        vectors++;
        if (seg !== SEG_EXP[0]) begin
            miscompares++;
            $display("[TB] FAIL reset_seg: got %b expected %b", seg, SEG_EXP[0]);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; result = 4'hF; V = 1'b0; Z = 1'b0; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_valid: got %b expected 1", out_valid);
        end
        vectors++;
        if (seg !== SEG_EXP[15] || led !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL basic_display: got seg=%b led=%b expected seg=%b led=00", seg, led, SEG_EXP[15]);
        end
        vectors++;
        if ({sticky_V, sticky_Z} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL basic_sticky: got %b expected 00", {sticky_V, sticky_Z});
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || seg !== SEG_EXP[15]) begin
            miscompares++;
            $display("[TB] FAIL basic_drain: got valid=%b seg=%b expected valid=0 seg=%b", out_valid, seg, SEG_EXP[15]);
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_seg;
        in_valid = 1'b1; result = 4'h0; V = 1'b1; Z = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (sticky_V !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL blink_sticky_v: got %b expected 1", sticky_V);
        end
        for (int i = 0; i < 16; i++) begin
            exp_seg = (((i / 4) % 2) == 0) ? SEG_EXP[0] : SEG_OFF;
            vectors++;
            if (seg !== exp_seg || led !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL blink_cycle%0d: got seg=%b led=%b expected seg=%b led=10", i, seg, led, exp_seg);
            end
            step();
        end
    endtask

    task automatic test_sticky_z();
        in_valid = 1'b1; result = 4'h0; V = 1'b0; Z = 1'b0;
        step();
        vectors++;
        if (sticky_Z !== 1'b0 || seg !== SEG_EXP[0]) begin
            miscompares++;
            $display("[TB] FAIL sticky_z_hold: got sticky_Z=%b seg=%b expected 0 %b", sticky_Z, seg, SEG_EXP[0]);
        end
        Z = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (sticky_Z !== 1'b1 || led !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL sticky_z_set: got sticky_Z=%b led=%b expected 1 01", sticky_Z, led);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        vectors++;
        if ({sticky_V, sticky_Z} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL sticky_clear: got %b expected 00", {sticky_V, sticky_Z});
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; result = 4'h3; V = 1'b0; Z = 1'b0;
        step();
        result = 4'hA;
        step();
        vectors++;
        if (in_ready !== 1'b0 || out_result !== 4'h3 || seg !== SEG_EXP[3]) begin
            miscompares++;
            $display("[TB] FAIL stall: got in_ready=%b result=%h seg=%b expected 0 3 %b", in_ready, out_result, seg, SEG_EXP[3]);
        end
        out_ready = 1'b1; result = 4'h6;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL passthru_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 4'h6 || seg !== SEG_EXP[6]) begin
            miscompares++;
            $display("[TB] FAIL refill: got valid=%b result=%h seg=%b expected 1 6 %b", out_valid, out_result, seg, SEG_EXP[6]);
        end
    endtask

    task automatic test_drain_reset();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || seg !== SEG_EXP[6]) begin
            miscompares++;
            $display("[TB] FAIL drain_empty: got valid=%b seg=%b expected 0 %b", out_valid, seg, SEG_EXP[6]);
        end
        in_valid = 1'b1; result = 4'h5; V = 1'b1; Z = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (seg !== SEG_OFF) begin
            miscompares++;
            $display("[TB] FAIL mid_blink_dark: got %b expected %b", seg, SEG_OFF);
        end
        rst_n = 1'b0; in_valid = 1'b1; result = 4'h7; V = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_result, out_V, out_Z, sticky_V, sticky_Z, led} !== 11'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_state: got %b expected 0", {out_valid, out_result, out_V, out_Z, sticky_V, sticky_Z, led});
        end
        vectors++;
        if (seg !== SEG_EXP[0]) begin
            miscompares++;
            $display("[TB] FAIL midrst_seg: got %b expected %b", seg, SEG_EXP[0]);
        end
    endtask

    task automatic test_clear_collision();
        out_ready = 1'b1;
        in_valid = 1'b1; result = 4'h1; V = 1'b1; Z = 1'b0;
        step();
        vectors++;
        if (sticky_V !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL collide_pre: got %b expected 1", sticky_V);
        end
        result = 4'h9; V = 1'b0; clear = 1'b1;
        step();
        vectors++;
        if (sticky_V !== 1'b0 || seg !== SEG_EXP[9]) begin
            miscompares++;
            $display("[TB] FAIL collide_clear: got sticky_V=%b seg=%b expected 0 %b", sticky_V, seg, SEG_EXP[9]);
        end
        result = 4'h2; V = 1'b1;
        step();
        in_valid = 1'b0; clear = 1'b0;
        vectors++;
        if (sticky_V !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL collide_set: got %b expected 1", sticky_V);
        end
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL final_empty: got %b expected 0", out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; result = 4'h0; V = 1'b0; Z = 1'b0;
        out_ready = 1'b0; clear = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_blink();
        test_sticky_z();
        test_back_to_back();
        test_drain_reset();
        test_clear_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 4-bit multiplier / ALU datapath.
- Captures the combinational result nibble and its V/Z flags into a one-entry buffer with a valid/ready handshake toward a downstream consumer.
- Keeps sticky flag accumulators and drives the board's 7-segment digit and flag LEDs from the last captured result. The digit blinks while the held result overflowed.

Parameters:
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; legal range >= 2; sim benches use 4.
- SEG_ACTIVE_LOW, 1, 1 = segment lit by driving 0 (board default); 0 = inverted polarity.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream result/V/Z valid this cycle
- in_ready  out  1  stage can accept a result this cycle
- result  in  4  multiplier/ALU low nibble
- V  in  1  overflow flag from upstream
- Z  in  1  zero flag from upstream
- out_valid  out  1  buffered result available
- out_ready  in  1  downstream accepts buffered result
- out_result  out  4  buffered result
- out_V  out  1  buffered overflow flag
- out_Z  out  1  buffered zero flag
- clear  in  1  clears sticky flags
- sticky_V  out  1  set if any accepted result had V=1 since last clear/reset
- sticky_Z  out  1  set if any accepted result had Z=1 since last clear/reset
- seg  out  7  digit segments {g,f,e,d,c,b,a}
- led  out  2  {V,Z} of the display register

Behaviour:
- Reset: the synchronous reset acts on a clk edge with rst_n=0. All registers clear:
  - out_valid=0, out_result=0, out_V=0, out_Z=0, sticky_V=0, sticky_Z=0.
  - The display register is 0 with flags 0, so seg shows "0" and led=2'b00.
  - The blink counter and phase are 0, with the digit in the lit phase.
- Reset mid-transfer discards the buffered entry. No handshake completes on the reset cycle.
- FSM has two states:
  - EMPTY: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=out_ready (pass-through refill).
- A transfer "accept" is in_valid & in_ready. A transfer "drain" is out_valid & out_ready.
- EMPTY, accept: go to FULL. The buffer loads {result,V,Z}. Latency is 1 cycle from accept to out_valid.
- FULL:
  - drain & accept: stay FULL, buffer reloads with the new value.
  - drain only: go to EMPTY; buffer contents are held but don't care.
  - neither: hold. Outputs are stable while out_valid=1 and out_ready=0.
- Inputs are sampled only on accept. result/V/Z may change freely otherwise.
- Display register: loads {result,V,Z} on every accept, independent of draining. It persists when the FSM goes to EMPTY.
- Sticky flags, next state:
  - sticky_X <= (sticky_X & ~clear) | (accept & X).
  - Clear and an accept with X=1 in the same cycle leaves sticky_X=1.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and wraps. The wrap toggles the phase.
  - Every accept resets the counter to 0 and the phase to lit, so a new result is visible immediately.
  - If the display V=0, the phase is ignored and the digit is always lit.
  - If the display V=1, the dark phase blanks all segments to the off level.
- Segment decode is hex 0-F, standard patterns with SEG_ACTIVE_LOW=1:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - With SEG_ACTIVE_LOW=0, the bitwise inverse of each pattern.
- led is not blinked.
- No combinational path from result/V/Z to any output. in_ready depends combinationally on out_ready only.

Decomposition:
- Shared package alu_pkg holds:
  - typedef nibble_t (logic [3:0]);
  - typedef struct result_t {nibble_t value; logic V; logic Z;};
  - enum stage_state_t {EMPTY, FULL};
  - SEG_BLANK constant and the 16-entry segment pattern constant.
- One sub-module, hex_to_7seg: a combinational nibble-to-segment decoder with a polarity parameter. It is reusable for the other ALU operation displays.

Test Plan:
- Reset, then accept result=4'hF, V=0, Z=0 (3*5) -> next cycle out_valid=1, out_result=F, seg=0001110, led=00, sticky flags 0.
- Accept result=0, V=1, Z=0 (4*4) with BLINK_DIV=4 -> seg=1000000 for 4 cycles, then 1111111 for 4 cycles, repeating; led=10; sticky_V=1.
- Accept result=0, V=0, Z=0 -> sticky_Z stays 0. Then accept Z=1 (0*7) -> sticky_Z=1. Then pulse clear with no accept -> both sticky flags 0 next cycle.
- Hold out_ready=0 with an entry FULL -> in_ready=0, a second in_valid is ignored, out_result is unchanged. Then assert out_ready with in_valid and result=4'h6 -> same-cycle drain + refill, out_result=6, out_valid stays 1.
- Drain to EMPTY -> out_valid=0 while seg keeps the last digit. Then hold rst_n=0 for one edge mid-blink -> all outputs at reset values, seg=1000000.
- Accept (result=4'h9, V=0, Z=0) with clear=1 and sticky_V=1 in the same cycle -> sticky_V=0. Accept with V=1 and clear=1 in the same cycle -> sticky_V=1.
